vec_accum: RTL and testbench

//  Streaming element-wise accumulator directly downstream of the vec_mult stage.

---
 rtl/vec_accum_pkg.sv | 27 ++
 rtl/vec_sat.sv | 39 +++
 rtl/vec_accum.sv | 108 ++++++++++
 tb/tb_vec_accum.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/vec_accum_pkg.sv
// Shared definitions for the vec_mult -> vec_accum datapath: vector geometry,
// fixed-point formats and the accumulator-state encoding.
package vec_accum_pkg;

    localparam int ARR_WIDTH = 4;
    localparam int FXP_N     = 16;
    localparam int FXP_R     = 8;

    typedef logic signed [FXP_N-1:0]          fxp_t;
    typedef logic [ARR_WIDTH-1:0][FXP_N-1:0]  fxp_vec_t;

    // Encoded as plain constants so older tools can consume the same package.
    typedef logic [0:0] acc_state_t;
    localparam acc_state_t ST_ACC = 1'b0;
    localparam acc_state_t ST_OUT = 1'b1;

    // Accumulator width that holds max_beats full-scale Q(FXP_N,FXP_R) beats.
    function automatic int acc_width(input int max_beats);
        return FXP_N + $clog2(max_beats);
    endfunction

    // Beat counter width; at least one bit even for single-beat groups.
    function automatic int cnt_width(input int max_beats);
        return (max_beats > 1) ? $clog2(max_beats) : 1;
    endfunction

endpackage

// File: rtl/vec_sat.sv
// Combinational per-element ACC_W -> FXP_N narrowing with a per-element clamp flag.
// Define VEC_ACCUM_SAT_EN to clamp; otherwise the low FXP_N bits wrap.
module vec_sat
    import vec_accum_pkg::*;
#(
    parameter int ACC_W = FXP_N + 3
)
(
    input  logic [ARR_WIDTH-1:0][ACC_W-1:0] acc,
    output fxp_vec_t                        data,
    output logic [ARR_WIDTH-1:0]            sat
);

    generate
        for (genvar gi = 0; gi < ARR_WIDTH; gi++) begin : g_elem
`ifdef VEC_ACCUM_SAT_EN
            logic [ACC_W-FXP_N:0] top_bits;
            logic                 ovf;

            // The value fits in FXP_N bits only if every bit above the
            // narrowed sign bit matches it.
            assign top_bits = acc[gi][ACC_W-1:FXP_N-1];
            assign ovf      = !((&top_bits) || (~|top_bits));

            assign data[gi] = !ovf ? acc[gi][FXP_N-1:0]
                            : acc[gi][ACC_W-1] ? {1'b1, {(FXP_N-1){1'b0}}}
                                               : {1'b0, {(FXP_N-1){1'b1}}};
            assign sat[gi]  = ovf;
`else
            logic unused_hi;

            assign unused_hi = ^acc[gi][ACC_W-1:FXP_N];
            assign data[gi]  = acc[gi][FXP_N-1:0];
            assign sat[gi]   = 1'b0;
`endif
        end
    endgenerate

endmodule

// File: rtl/vec_accum.sv
// Streaming element-wise group accumulator behind vec_mult, valid/ready on both sides.
// Saturating narrowing is enabled by defining VEC_ACCUM_SAT_EN.
module vec_accum
    import vec_accum_pkg::*;
#(
    parameter int MAX_BEATS = 8
)
(
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [ARR_WIDTH*FXP_N-1:0]   in_data,
    input  logic                         in_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [ARR_WIDTH*FXP_N-1:0]   out_data,
    output logic [ARR_WIDTH-1:0]         out_sat,
    output logic                         out_trunc
);

    localparam int ACC_W = acc_width(MAX_BEATS);
    localparam int CNT_W = cnt_width(MAX_BEATS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BEATS - 1);

    acc_state_t                       state_reg;
    logic [CNT_W-1:0]                 beat_cnt_reg;
    logic [ARR_WIDTH-1:0][ACC_W-1:0]  acc_reg;
    logic [ARR_WIDTH-1:0][ACC_W-1:0]  acc_next;
    fxp_vec_t                         out_data_reg;
    logic [ARR_WIDTH-1:0]             out_sat_reg;
    logic                             out_trunc_reg;

    fxp_vec_t                         in_vec;
    fxp_vec_t                         narrow_data;
    logic [ARR_WIDTH-1:0]             narrow_sat;
    logic                             accept;
    logic                             at_limit;
    logic                             close;

    assign in_vec   = in_data;
    assign in_ready = (state_reg == ST_ACC);
    assign accept   = in_valid && in_ready;
    assign at_limit = (beat_cnt_reg == LAST_CNT);
    assign close    = accept && (in_last || at_limit);

    // First beat of a group loads rather than adds, so no clear cycle is needed.
    generate
        for (genvar gi = 0; gi < ARR_WIDTH; gi++) begin : g_acc
            logic [ACC_W-1:0] sext_beat;
            logic [ACC_W-1:0] base;

            assign sext_beat    = {{(ACC_W-FXP_N){in_vec[gi][FXP_N-1]}}, in_vec[gi]};
            assign base         = (beat_cnt_reg == '0) ? '0 : acc_reg[gi];
            assign acc_next[gi] = base + sext_beat;
        end
    endgenerate

    vec_sat #(
        .ACC_W (ACC_W)
    ) u_vec_sat (
        .acc   (acc_next),
        .data  (narrow_data),
        .sat   (narrow_sat)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= ST_ACC;
            beat_cnt_reg  <= '0;
            acc_reg       <= '0;
            out_data_reg  <= '0;
            out_sat_reg   <= '0;
            out_trunc_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_ACC: begin
                    if (accept) begin
                        acc_reg <= acc_next;
                        if (close) begin
                            state_reg     <= ST_OUT;
                            beat_cnt_reg  <= '0;
                            out_data_reg  <= narrow_data;
                            out_sat_reg   <= narrow_sat;
                            // An explicit last on the final allowed beat is a normal close.
                            out_trunc_reg <= at_limit && !in_last;
                        end else begin
                            beat_cnt_reg  <= beat_cnt_reg + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    if (out_ready) begin
                        state_reg     <= ST_ACC;
                        beat_cnt_reg  <= '0;
                        out_trunc_reg <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign out_valid = (state_reg == ST_OUT);
    assign out_data  = out_data_reg;
    assign out_sat   = out_sat_reg;
    assign out_trunc = out_trunc_reg;

endmodule

// File: tb/tb_vec_accum.sv
// Self-checking bench for vec_accum: directed scenarios then random groups against
// an integer-arithmetic reference model; honours VEC_ACCUM_SAT_EN.
module tb_vec_accum;
    import vec_accum_pkg::*;

    localparam int MAXB = 8;

    logic                        clock;
    logic                        reset_n;
    logic                        in_valid;
    logic                        in_ready;
    logic [ARR_WIDTH*FXP_N-1:0]  in_data;
    logic                        in_last;
    logic                        out_valid;
    logic                        out_ready;
    logic [ARR_WIDTH*FXP_N-1:0]  out_data;
    logic [ARR_WIDTH-1:0]        out_sat;
    logic                        out_trunc;

    int compared   = 0;
    int mismatched = 0;
    int group_no   = 0;

    logic signed [FXP_N-1:0] beats [MAXB][ARR_WIDTH];

    vec_accum #(
        .MAX_BEATS (MAXB)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .out_trunc (out_trunc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fill(input int b, input logic [FXP_N-1:0] val);
        for (int e = 0; e < ARR_WIDTH; e++) beats[b][e] = val;
    endtask

    function automatic logic [ARR_WIDTH*FXP_N-1:0] pack_beat(input int b);
        logic [ARR_WIDTH*FXP_N-1:0] v;
        for (int e = 0; e < ARR_WIDTH; e++) v[e*FXP_N +: FXP_N] = beats[b][e];
        return v;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Drives n beats (last flagged on the final one if use_last), checks the
    // result against plain integer sums, holds out_ready low for hold cycles.
    task automatic run_group(input int n, input bit use_last, input int hold);
        int                          sum;
        logic [ARR_WIDTH*FXP_N-1:0]  exp_data;
        logic [ARR_WIDTH-1:0]        exp_sat;
        logic                        exp_trunc;
        logic [31:0]                 sum_bits;

        exp_sat   = '0;
        exp_trunc = !use_last && (n == MAXB);
        for (int e = 0; e < ARR_WIDTH; e++) begin
            sum = 0;
            for (int b = 0; b < n; b++) sum += int'(beats[b][e]);
            sum_bits = sum;
`ifdef VEC_ACCUM_SAT_EN
            if (sum > 32767) begin
                exp_data[e*FXP_N +: FXP_N] = 16'h7FFF;
                exp_sat[e] = 1'b1;
            end else if (sum < -32768) begin
                exp_data[e*FXP_N +: FXP_N] = 16'h8000;
                exp_sat[e] = 1'b1;
            end else begin
                exp_data[e*FXP_N +: FXP_N] = sum_bits[15:0];
            end
`else
            exp_data[e*FXP_N +: FXP_N] = sum_bits[15:0];
`endif
        end

        for (int b = 0; b < n; b++) begin
            in_valid = 1'b1;
            in_data  = pack_beat(b);
            in_last  = use_last && (b == n - 1);
            check("in_ready_beat", 64'(in_ready), 64'(1));
            check("out_valid_beat", 64'(out_valid), 64'(0));
            step();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;

        check("out_valid_close", 64'(out_valid), 64'(1));
        check("in_ready_close", 64'(in_ready), 64'(0));
        check("out_data", 64'(out_data), 64'(exp_data));
        check("out_sat", 64'(out_sat), 64'(exp_sat));
        check("out_trunc", 64'(out_trunc), 64'(exp_trunc));

        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            in_data  = {$urandom, $urandom};
            step();
            check("hold_valid", 64'(out_valid), 64'(1));
            check("hold_data", 64'(out_data), 64'(exp_data));
            check("hold_in_ready", 64'(in_ready), 64'(0));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("out_valid_after_hs", 64'(out_valid), 64'(0));
        check("in_ready_after_hs", 64'(in_ready), 64'(1));
        check("out_trunc_after_hs", 64'(out_trunc), 64'(0));

        $display("group %0d: beats=%0d last=%0b hold=%0d exp_data=%h exp_sat=%h exp_trunc=%0b",
                 group_no, n, use_last, hold, exp_data, exp_sat, exp_trunc);
        group_no++;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid"}, 64'(out_valid), 64'(0));
        check({tag, "_out_data"}, 64'(out_data), 64'(0));
        check({tag, "_out_sat"}, 64'(out_sat), 64'(0));
        check({tag, "_out_trunc"}, 64'(out_trunc), 64'(0));
        check({tag, "_in_ready"}, 64'(in_ready), 64'(1));
    endtask

    initial begin
        int n;
        bit use_last;

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        #2;
        check_reset_outputs("reset");
        step();
        reset_n = 1'b1;
        step();

        // Single beat of 1.0
        fill(0, 16'h0100);
        run_group(1, 1'b1, 0);

        // Three beats of 0.5 -> 1.5, with a held output
        for (int b = 0; b < 3; b++) fill(b, 16'h0080);
        run_group(3, 1'b1, 5);

        // -1 + -1 + 0.5 -> -1.5
        fill(0, 16'hFF00);
        fill(1, 16'hFF00);
        fill(2, 16'h0080);
        run_group(3, 1'b1, 0);

        // Overflow of the narrowed result
        for (int b = 0; b < 4; b++) fill(b, 16'h7000);
        run_group(4, 1'b1, 0);

        // Forced close at MAX_BEATS
        for (int b = 0; b < MAXB; b++) fill(b, 16'h0001);
        run_group(MAXB, 1'b0, 0);

        // in_last on the final allowed beat is a normal close
        for (int b = 0; b < MAXB; b++) fill(b, 16'h8000);
        run_group(MAXB, 1'b1, 0);

        // Reset mid-group discards the partial sum
        for (int b = 0; b < 3; b++) begin
            in_valid = 1'b1;
            in_data  = {ARR_WIDTH{16'h0100}};
            in_last  = 1'b0;
            step();
        end
        in_valid = 1'b0;
        reset_n  = 1'b0;
        #1;
        check_reset_outputs("reset_mid_group");
        step();
        reset_n = 1'b1;
        step();
        fill(0, 16'h0100);
        run_group(1, 1'b1, 0);

        // Reset while a result is pending drops it
        in_valid = 1'b1;
        in_data  = {ARR_WIDTH{16'h0240}};
        in_last  = 1'b1;
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("pending_valid", 64'(out_valid), 64'(1));
        reset_n = 1'b0;
        #1;
        check_reset_outputs("reset_mid_out");
        step();
        reset_n = 1'b1;
        step();
        fill(0, 16'h0003);
        fill(1, 16'hFFFE);
        run_group(2, 1'b1, 0);

        // Random groups: mix of small values and full-range values
        for (int g = 0; g < 24; g++) begin
            n        = $urandom_range(1, MAXB);
            use_last = (n < MAXB) ? 1'b1 : 1'($urandom_range(0, 1));
            for (int b = 0; b < n; b++) begin
                for (int e = 0; e < ARR_WIDTH; e++) begin
                    if ($urandom_range(0, 1) == 0)
                        beats[b][e] = 16'($urandom_range(0, 1023)) - 16'd512;
                    else
                        beats[b][e] = 16'($urandom);
                end
            end
            run_group(n, use_last, $urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
